// File: rtl/multi_channel_fp_frontend.sv
// ============================================================================
// Module   : multi_channel_fp_frontend
// Purpose  : N-channel uint8 -> float front end with raster tagging,
//            valid/ready flow control and frame-sync error detection.
//            Optional: MULTI_CHANNEL_FP_FRONTEND_SAT_COUNT_EN adds sat_count_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_channel_fp_frontend #(
    parameter int CHANNELS     = 2,
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 400,
    parameter int EXP_WIDTH    = 5,
    parameter int FRAC_WIDTH   = 10,
    parameter int COORD_WIDTH  = 16
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [CHANNELS*8-1:0]                         uint8_i,
    input  logic                                          sof_i,
    input  logic                                          valid_i,
    output logic                                          ready_o,
    output logic [CHANNELS*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]  fp_o,
    output logic [COORD_WIDTH-1:0]                        col_o,
    output logic [COORD_WIDTH-1:0]                        row_o,
    output logic                                          sof_o,
    output logic                                          eol_o,
    output logic                                          eof_o,
    output logic                                          valid_o,
    input  logic                                          ready_i,
    output logic                                          sync_err_o,
`ifdef MULTI_CHANNEL_FP_FRONTEND_SAT_COUNT_EN
    output logic [31:0]                                   sat_count_o,
`endif
    output logic [15:0]                                   frame_count_o
);

    localparam int c_fp_w = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam logic [EXP_WIDTH-1:0]   c_bias     = EXP_WIDTH'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic [COORD_WIDTH-1:0] c_last_col = COORD_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] c_last_row = COORD_WIDTH'(IMAGE_HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] c_one      = COORD_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [COORD_WIDTH-1:0] r_col;
    logic [COORD_WIDTH-1:0] r_row;
    logic [15:0]            r_frame_count;
    logic                   r_sync_err;

    logic                   w_adv;
    logic                   w_acc;
    logic                   w_take;
    logic                   w_sync_err;
    logic [COORD_WIDTH-1:0] w_col;
    logic [COORD_WIDTH-1:0] w_row;
    logic                   w_sof_tag;
    logic                   w_eol_tag;
    logic                   w_eof_tag;

    // Stage 1 registers
    logic                               r_valid_s1;
    logic [CHANNELS*8-1:0]              r_pix_s1;
    logic [CHANNELS-1:0][2:0]           r_lod_s1;
    logic [CHANNELS-1:0]                r_nz_s1;
    logic [COORD_WIDTH-1:0]             r_col_s1;
    logic [COORD_WIDTH-1:0]             r_row_s1;
    logic                               r_sof_s1;
    logic                               r_eol_s1;
    logic                               r_eof_s1;

    // Stage 2 registers
    logic                               r_valid_s2;
    logic [CHANNELS*c_fp_w-1:0]         r_fp_s2;
    logic [COORD_WIDTH-1:0]             r_col_s2;
    logic [COORD_WIDTH-1:0]             r_row_s2;
    logic                               r_sof_s2;
    logic                               r_eol_s2;
    logic                               r_eof_s2;

    logic [CHANNELS-1:0][2:0]           w_lod;
    logic [CHANNELS-1:0]                w_nz;
    logic [CHANNELS*c_fp_w-1:0]         w_fp;

    function automatic logic [2:0] lead_one(input logic [7:0] v);
        logic [2:0] p;
        p = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) p = 3'(i);
        end
        return p;
    endfunction

    assign w_adv   = !r_valid_s2 || ready_i;
    assign ready_o = w_adv;
    assign w_acc   = valid_i && w_adv;
    // Before sync only a sof beat may enter; everything else is silently dropped.
    assign w_take  = w_acc && ((r_state == ST_RUN) || sof_i);

    // A sof beat always restarts the raster at (0,0).
    assign w_col      = sof_i ? '0 : r_col;
    assign w_row      = sof_i ? '0 : r_row;
    assign w_sync_err = w_acc && sof_i && (r_state == ST_RUN) &&
                        ((r_col != '0) || (r_row != '0));

    assign w_sof_tag = (w_col == '0) && (w_row == '0);
    assign w_eol_tag = (w_col == c_last_col);
    assign w_eof_tag = w_eol_tag && (w_row == c_last_row);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_take)              w_state_nxt = ST_RUN;
            ST_RUN:  if (w_take && w_eof_tag) w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_col         <= '0;
            r_row         <= '0;
            r_frame_count <= '0;
            r_sync_err    <= 1'b0;
        end else begin
            if (w_sync_err) r_sync_err <= 1'b1;
            if (w_take) begin
                if (w_eol_tag) begin
                    r_col <= '0;
                    if (w_eof_tag) begin
                        r_row         <= '0;
                        r_frame_count <= r_frame_count + 16'd1;
                    end else begin
                        r_row <= w_row + c_one;
                    end
                end else begin
                    r_col <= w_col + c_one;
                    r_row <= w_row;
                end
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lod
        assign w_lod[k] = lead_one(uint8_i[8*k +: 8]);
        assign w_nz[k]  = |uint8_i[8*k +: 8];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid_s1 <= 1'b0;
            r_pix_s1   <= '0;
            r_lod_s1   <= '0;
            r_nz_s1    <= '0;
            r_col_s1   <= '0;
            r_row_s1   <= '0;
            r_sof_s1   <= 1'b0;
            r_eol_s1   <= 1'b0;
            r_eof_s1   <= 1'b0;
        end else if (w_adv) begin
            r_valid_s1 <= w_take;
            r_pix_s1   <= uint8_i;
            r_lod_s1   <= w_lod;
            r_nz_s1    <= w_nz;
            r_col_s1   <= w_col;
            r_row_s1   <= w_row;
            r_sof_s1   <= w_sof_tag;
            r_eol_s1   <= w_eol_tag;
            r_eof_s1   <= w_eof_tag;
        end
    end

    // Normalise so the leading one drops off; the remaining bits become the fraction.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_pack
        logic [6:0]            w_norm;
        logic [EXP_WIDTH-1:0]  w_exp;
        logic [FRAC_WIDTH-1:0] w_frac;
        assign w_norm = 7'(r_pix_s1[8*k +: 8] << (3'd7 - r_lod_s1[k]));
        assign w_exp  = EXP_WIDTH'(r_lod_s1[k]) + c_bias;
        assign w_frac = FRAC_WIDTH'(w_norm) << (FRAC_WIDTH - 7);
        assign w_fp[k*c_fp_w +: c_fp_w] = r_nz_s1[k] ? {1'b0, w_exp, w_frac} : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid_s2 <= 1'b0;
            r_fp_s2    <= '0;
            r_col_s2   <= '0;
            r_row_s2   <= '0;
            r_sof_s2   <= 1'b0;
            r_eol_s2   <= 1'b0;
            r_eof_s2   <= 1'b0;
        end else if (w_adv) begin
            r_valid_s2 <= r_valid_s1;
            r_fp_s2    <= w_fp;
            r_col_s2   <= r_col_s1;
            r_row_s2   <= r_row_s1;
            r_sof_s2   <= r_sof_s1;
            r_eol_s2   <= r_eol_s1;
            r_eof_s2   <= r_eof_s1;
        end
    end

`ifdef MULTI_CHANNEL_FP_FRONTEND_SAT_COUNT_EN
    logic [31:0] r_sat_acc;
    logic [31:0] r_sat_count;
    logic [31:0] w_beat_sat;

    always_comb begin
        w_beat_sat = 32'd0;
        for (int k = 0; k < CHANNELS; k++) begin
            if ((uint8_i[8*k +: 8] == 8'd0) || (uint8_i[8*k +: 8] == 8'd255))
                w_beat_sat = w_beat_sat + 32'd1;
        end
    end

    // A sof beat opens a fresh frame, dropping whatever a broken frame had gathered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sat_acc   <= '0;
            r_sat_count <= '0;
        end else if (w_take) begin
            if (w_eof_tag) begin
                r_sat_count <= r_sat_acc + w_beat_sat;
                r_sat_acc   <= '0;
            end else if (sof_i) begin
                r_sat_acc <= w_beat_sat;
            end else begin
                r_sat_acc <= r_sat_acc + w_beat_sat;
            end
        end
    end

    assign sat_count_o = r_sat_count;
`endif

    assign fp_o          = r_fp_s2;
    assign col_o         = r_col_s2;
    assign row_o         = r_row_s2;
    assign sof_o         = r_sof_s2;
    assign eol_o         = r_eol_s2;
    assign eof_o         = r_eof_s2;
    assign valid_o       = r_valid_s2;
    assign sync_err_o    = r_sync_err;
    assign frame_count_o = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_fp_frontend.sv
// ============================================================================
// Module   : tb_multi_channel_fp_frontend
// Purpose  : Directed self-checking bench for multi_channel_fp_frontend on a
//            reduced 8x4 raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_channel_fp_frontend;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [15:0] uint8_i = '0;
    logic        sof_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] fp_o;
    logic [15:0] col_o;
    logic [15:0] row_o;
    logic        sof_o, eol_o, eof_o, valid_o;
    logic        ready_i = 1'b1;
    logic        sync_err_o;
    logic [15:0] frame_count_o;
`ifdef MULTI_CHANNEL_FP_FRONTEND_SAT_COUNT_EN
    logic [31:0] sat_count_o;
`endif

    multi_channel_fp_frontend #(
        .CHANNELS(2), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .COORD_WIDTH(16)
    ) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .uint8_i(uint8_i), .sof_i(sof_i),
        .valid_i(valid_i), .ready_o(ready_o), .fp_o(fp_o), .col_o(col_o),
        .row_o(row_o), .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o),
        .valid_o(valid_o), .ready_i(ready_i), .sync_err_o(sync_err_o),
`ifdef MULTI_CHANNEL_FP_FRONTEND_SAT_COUNT_EN
        .sat_count_o(sat_count_o),
`endif
        .frame_count_o(frame_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Hand-computed half-precision encodings of the pixel table.
    logic [7:0]  tbl_px [6] = '{8'd1,     8'd0,     8'd3,     8'd255,   8'd128,   8'd2};
    logic [15:0] tbl_fp [6] = '{16'h3C00, 16'h0000, 16'h4200, 16'h5BF8, 16'h5800, 16'h4000};

    typedef struct packed {
        logic [31:0] fp;
        logic [15:0] col;
        logic [15:0] row;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    exp_t  q[$];
    int    n_total = 0;
    int    n_bad   = 0;
    int    bi      = 0;
    logic  m_run   = 1'b0;
    logic  m_err   = 1'b0;
    int    m_col   = 0;
    int    m_row   = 0;
    int    m_frames = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_accept(input logic s);
        exp_t e;
        if (!m_run && !s) return;
        if (s) begin
            if (m_run && (m_col != 0 || m_row != 0)) m_err = 1'b1;
            m_col = 0;
            m_row = 0;
            m_run = 1'b1;
        end
        e.fp  = {tbl_fp[(bi + 1) % 6], tbl_fp[bi % 6]};
        e.col = 16'(m_col);
        e.row = 16'(m_row);
        e.sof = (m_col == 0 && m_row == 0);
        e.eol = (m_col == W - 1);
        e.eof = (m_col == W - 1 && m_row == H - 1);
        q.push_back(e);
        if (m_col == W - 1) begin
            m_col = 0;
            if (m_row == H - 1) begin
                m_row = 0;
                m_frames++;
                m_run = 1'b0;
            end else begin
                m_row++;
            end
        end else begin
            m_col++;
        end
    endtask

    task automatic step(input logic v, input logic s, input logic r, output logic acc);
        exp_t e;
        @(posedge clk_i);
        #1;
        valid_i = v;
        sof_i   = s;
        ready_i = r;
        uint8_i = {tbl_px[(bi + 1) % 6], tbl_px[bi % 6]};
        #1;
        chk("frame_count", frame_count_o, m_frames);
        chk("sync_err", sync_err_o, m_err);
        if (valid_o) begin
            if (q.size() == 0) begin
                chk("spurious_out", valid_o, 1'b0);
            end else begin
                e = q[0];
                chk("fp",  fp_o,  e.fp);
                chk("col", col_o, e.col);
                chk("row", row_o, e.row);
                chk("sof", sof_o, e.sof);
                chk("eol", eol_o, e.eol);
                chk("eof", eof_o, e.eof);
                if (r) void'(q.pop_front());
                else   chk("ready_o_stall", ready_o, 1'b0);
            end
        end
        acc = v && ready_o;
        if (acc) begin
            model_accept(s);
            bi++;
        end
    endtask

    task automatic send(input int n, input logic first_sof, input int stall_at);
        int   got;
        int   cyc;
        logic a;
        logic s;
        logic r;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 1000) begin
            s = first_sof && (got == 0);
            r = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
            step(1'b1, s, r, a);
            if (a) got++;
            cyc++;
        end
        if (got < n) chk("send_timeout", 64'(got), 64'(n));
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, a);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_fp"},     fp_o, 32'h0);
        chk({tag, "_col"},    col_o, 16'h0);
        chk({tag, "_row"},    row_o, 16'h0);
        chk({tag, "_flags"},  {sof_o, eol_o, eof_o, valid_o, sync_err_o}, 5'b0);
        chk({tag, "_frames"}, frame_count_o, 16'h0);
        chk({tag, "_ready"},  ready_o, 1'b1);
    endtask

    initial begin
        #23;
        chk_reset_state("rst0");
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;

        // Beats before any sof must vanish.
        send(10, 1'b0, -1);
        idle(3);
        chk("presync_empty", 64'(q.size()), 64'd0);

        // Full frame with a 5-cycle downstream stall mid-row.
        send(W * H, 1'b1, 4);
        idle(4);
        chk("frame1_drained", 64'(q.size()), 64'd0);
        chk("frame1_count", frame_count_o, 16'd1);

        // sof arriving at (3,1) is a sync error and restarts the raster.
        send(W + 3, 1'b1, -1);
        send(1, 1'b1, -1);
        idle(1);
        chk("sync_err_set", sync_err_o, 1'b1);
        chk("sync_frames_hold", frame_count_o, 16'd1);
        send(W * H - 1, 1'b0, -1);
        idle(4);
        chk("frame2_drained", 64'(q.size()), 64'd0);
        chk("frame2_count", frame_count_o, 16'd2);

        // Asynchronous reset in the middle of a frame.
        send(W + 5, 1'b1, -1);
        #3;
        rst_i = 1'b0;
        #1;
        chk_reset_state("rst_mid");
        q.delete();
        m_run = 1'b0; m_err = 1'b0; m_col = 0; m_row = 0; m_frames = 0;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3;
        rst_i = 1'b1;

        send(3, 1'b0, -1);
        idle(3);
        chk("post_rst_drop", 64'(q.size()), 64'd0);
        send(W * H, 1'b1, -1);
        idle(4);
        chk("frame3_drained", 64'(q.size()), 64'd0);
        chk("frame3_count", frame_count_o, 16'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_channel_fp_frontend.md
Name: multi_channel_fp_frontend

Overview:
- N-channel successor to the single-channel uint8→fp front end. Converts CHANNELS parallel uint8 pixel streams to a parametrised float format (EXP_WIDTH/FRAC_WIDTH).
- Generates col/row raster tags internally, so top-levels no longer register col/row externally.
- Adds valid/ready backpressure, frame-boundary tagging and frame-sync error detection.
- Sits between the sensor/stream input and dual_scale_wrapper-class pipelines.

Parameters:
- CHANNELS, 2, number of parallel pixel channels (≥1).
- IMAGE_WIDTH, 512, pixels per row (≥2).
- IMAGE_HEIGHT, 400, rows per frame (≥2).
- EXP_WIDTH, 5, output exponent width (≥4).
- FRAC_WIDTH, 10, output fraction width (≥7, so conversion is exact).
- COORD_WIDTH, 16, width of col/row outputs (must hold IMAGE_WIDTH-1 and IMAGE_HEIGHT-1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- uint8_i  in  CHANNELS×8  packed pixels, channel k at [8k+7:8k]
- sof_i  in  1  start-of-frame marker for the beat
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- fp_o  out  CHANNELS×(1+EXP_WIDTH+FRAC_WIDTH)  converted pixels, same packing order
- col_o  out  COORD_WIDTH  column of the output beat
- row_o  out  COORD_WIDTH  row of the output beat
- sof_o / eol_o / eof_o  out  1 each  first pixel / last pixel of row / last pixel of frame
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream ready
- sync_err_o  out  1  sticky frame-sync error flag
- frame_count_o  out  16  number of completed frames, wraps at 2^16

Behaviour:
- Reset (rst_i=0, async): every output is 0 except ready_o, which is 1. Counters go to col=0, row=0. Pipeline is emptied.
- Pipeline: 2 stages.
  - S1: register pixels and tags; leading-one detect.
  - S2: pack the float value.
- Latency: 2 cycles from acceptance to valid_o with no stall.
- Advance rule: adv = !valid_s2 || ready_i. All stages shift only when adv=1. ready_o = adv.
- valid_o stays asserted and data stays stable while ready_i=0. Full throughput is 1 beat/cycle.
- Conversion, per channel, for value v:
  - v=0 → all zeros.
  - Otherwise let p = index of the MSB one (0..7). Sign = 0. Exponent = p + 2^(EXP_WIDTH-1) − 1. Fraction = v[p-1:0] left-aligned in FRAC_WIDTH, zero-filled.
- Raster counters advance on each accepted beat:
  - col increments; at IMAGE_WIDTH-1 it wraps to 0 and row increments.
  - At (IMAGE_WIDTH-1, IMAGE_HEIGHT-1) both wrap to 0 and frame_count increments.
- Output tags for each beat:
  - sof_o = (col==0 && row==0).
  - eol_o = (col==IMAGE_WIDTH-1).
  - eof_o = eol_o && (row==IMAGE_HEIGHT-1).
- Frame-sync state machine (IDLE, RUN):
  - IDLE: accepted beats with sof_i=0 are dropped. They produce no output and the counters hold.
  - IDLE: an accepted beat with sof_i=1 is tagged (0,0) and the state moves to RUN.
  - RUN: the state returns to IDLE after the eof beat is accepted.
  - RUN, sof_i=1 with counters ≠ (0,0): sync_err_o is set (sticky until reset). The counters force to (0,0) for that beat; it is emitted as sof_o. The partial frame is not counted.
  - sof_i=1 exactly at (0,0) while in RUN (back-to-back frames) is legal.
- Simultaneous eof acceptance and stall: frame_count_o increments at acceptance, not at output.
- Reset mid-frame: the partial frame is discarded and the state returns to IDLE.

Optional Feature:
- Macro: MULTI_CHANNEL_FP_FRONTEND_SAT_COUNT_EN.
- Defined:
  - Adds output sat_count_o (32-bit): per-frame count of channel samples equal to 0 or 255, summed over all channels.
  - The count accumulates on accepted beats and is latched to sat_count_o when the eof beat is accepted. The accumulator then clears.
  - On a sync error the accumulator clears without latching.
  - sat_count_o resets to 0.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Conversion, CHANNELS=2, defaults: (1,0)→(16'h3C00,16'h0000); (3,255)→(16'h4200,16'h5BF8).
- Full frame: sof_i on beat 0, then 204800 beats with ready_i=1 → first output at cycle 2 with sof_o=1 at (0,0); eol_o at col 511 on every row; eof_o at (511,399); frame_count_o=1.
- Backpressure: drop ready_i for 5 cycles mid-row → valid_o/fp_o/col_o held stable, ready_o=0; no beats lost or duplicated; col sequence stays contiguous.
- Pre-sync drop: 10 beats with sof_i=0 after reset, then sof_i → exactly 1 output stream starting at (0,0); the 10 beats produce no output.
- Sync error: sof_i asserted at (100,3) → sync_err_o=1 on the next cycle; that beat is output with sof_o=1 at (0,0); frame_count_o unchanged.
- Reset mid-frame: rst_i low at (200,50) → all outputs 0 and ready_o=1 immediately (async); the next frame requires sof_i.
